// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: constants and types shared by the fetch stage.
//   - default widths (PC, instruction, opcode, imem word address)
//   - NOP word, HALT opcode, fetch FSM state encoding
//   - isHalt helper used when FETCH_HALT_EN is defined
`ifndef OPCODE_BITS
`define OPCODE_BITS 6
`endif
`ifndef PC_BITS
`define PC_BITS 32
`endif
`ifndef INST_BITS
`define INST_BITS 32
`endif

package instruction_fetch_pkg;

  localparam int DEF_PC_BITS        = `PC_BITS;
  localparam int DEF_INST_BITS      = `INST_BITS;
  localparam int DEF_OPCODE_BITS    = `OPCODE_BITS;
  localparam int DEF_IMEM_ADDR_BITS = 10;

  // All-zero word decodes as an R-format op writing rd=0: harmless bubble.
  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetchState_e;

  function automatic logic isHalt(input logic [5:0] opcode);
    return (opcode == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-stage bus (control inputs, imem port, IF/ID outputs).
//   master: the fetch stage (drives imem address and IF/ID outputs)
//   slave : the surrounding pipeline / memory (drives start, stall, branch, imem data)
// With FETCH_HALT_EN defined the bus also carries o_halted.
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
#(
  parameter int PC_BITS        = DEF_PC_BITS,
  parameter int INST_BITS      = DEF_INST_BITS,
  parameter int IMEM_ADDR_BITS = DEF_IMEM_ADDR_BITS,
  parameter int OPCODE_BITS    = DEF_OPCODE_BITS
);
  logic                      i_start;
  logic                      i_stall;
  logic                      i_branch_taken;
  logic [PC_BITS-1:0]        i_branch_target;
  logic [IMEM_ADDR_BITS-1:0] o_imem_addr;
  logic [INST_BITS-1:0]      i_imem_data;
  logic [INST_BITS-1:0]      o_instruction;
  logic [OPCODE_BITS-1:0]    o_opcode;
  logic [PC_BITS-1:0]        o_pc_plus4;
  logic                      o_valid;
  logic                      o_running;
`ifdef FETCH_HALT_EN
  logic                      o_halted;

  modport master (
    input  i_start, i_stall, i_branch_taken, i_branch_target, i_imem_data,
    output o_imem_addr, o_instruction, o_opcode, o_pc_plus4, o_valid, o_running, o_halted
  );
  modport slave (
    output i_start, i_stall, i_branch_taken, i_branch_target, i_imem_data,
    input  o_imem_addr, o_instruction, o_opcode, o_pc_plus4, o_valid, o_running, o_halted
  );
`else
  modport master (
    input  i_start, i_stall, i_branch_taken, i_branch_target, i_imem_data,
    output o_imem_addr, o_instruction, o_opcode, o_pc_plus4, o_valid, o_running
  );
  modport slave (
    output i_start, i_stall, i_branch_taken, i_branch_target, i_imem_data,
    input  o_imem_addr, o_instruction, o_opcode, o_pc_plus4, o_valid, o_running
  );
`endif
endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// instruction_fetch_if_id_register: IF/ID pipeline register.
//   clk/rst        : clock, synchronous active-high reset
//   load           : capture instIn / pcPlus4In, mark valid
//   flush          : insert bubble (NOP, valid=0), keep pcPlus4Out
//   neither        : hold
//   instOut, pcPlus4Out, validOut : registered IF/ID contents
module instruction_fetch_if_id_register
  import instruction_fetch_pkg::*;
#(
  parameter int PC_BITS   = DEF_PC_BITS,
  parameter int INST_BITS = DEF_INST_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 flush,
  input  logic [INST_BITS-1:0] instIn,
  input  logic [PC_BITS-1:0]   pcPlus4In,
  output logic [INST_BITS-1:0] instOut,
  output logic [PC_BITS-1:0]   pcPlus4Out,
  output logic                 validOut
);

  // IF/ID storage; flush has priority over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      instOut    <= INST_BITS'(NOP_WORD);
      pcPlus4Out <= {PC_BITS{1'b0}};
      validOut   <= 1'b0;
    end else if (flush) begin
      instOut    <= INST_BITS'(NOP_WORD);
      pcPlus4Out <= pcPlus4Out;
      validOut   <= 1'b0;
    end else if (load) begin
      instOut    <= instIn;
      pcPlus4Out <= pcPlus4In;
      validOut   <= 1'b1;
    end else begin
      instOut    <= instOut;
      pcPlus4Out <= pcPlus4Out;
      validOut   <= validOut;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS IF stage with IF/ID register.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (master) : start/stall/branch controls, combinational imem port,
//                  IF/ID outputs (instruction, opcode, pc+4, valid, running)
// Optional macro FETCH_HALT_EN: adds HALTED state and o_halted; a fetched
// word with opcode 6'b111111 is latched and then stops the PC.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PC_BITS        = DEF_PC_BITS,
  parameter int INST_BITS      = DEF_INST_BITS,
  parameter int IMEM_ADDR_BITS = DEF_IMEM_ADDR_BITS,
  parameter int OPCODE_BITS    = DEF_OPCODE_BITS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  instruction_fetch_if.master bus
);

  localparam logic [PC_BITS-1:0] PC_STEP    = PC_BITS'(32'd4);
  localparam logic [PC_BITS-1:0] ALIGN_MASK = {{(PC_BITS-2){1'b1}}, 2'b00};

  fetchState_e          stateR;
  logic [PC_BITS-1:0]   pcR;
  logic [PC_BITS-1:0]   pcPlus4S;
  logic                 runningR;
  logic                 loadS;
  logic                 flushS;
  logic [INST_BITS-1:0] instS;
  logic [PC_BITS-1:0]   pcPlus4OutS;
  logic                 validS;
`ifdef FETCH_HALT_EN
  logic                 haltedR;
  logic                 haltFetchS;
`endif

  assign pcPlus4S        = pcR + PC_STEP;
  // Upper PC bits are dropped, so the imem address wraps every 4 KiB.
  assign bus.o_imem_addr = pcR[IMEM_ADDR_BITS+1:2];

  // IF/ID control: branch flushes (even under stall), stall holds, else load.
  always_comb begin
    loadS  = 1'b0;
    flushS = 1'b0;
`ifdef FETCH_HALT_EN
    haltFetchS = 1'b0;
`endif
    case (stateR)
      RUN: begin
        if (bus.i_branch_taken) begin
          flushS = 1'b1;
        end else if (bus.i_stall) begin
          loadS = 1'b0;
        end else begin
          loadS = 1'b1;
`ifdef FETCH_HALT_EN
          haltFetchS = isHalt(bus.i_imem_data[INST_BITS-1 -: 6]);
`endif
        end
      end
`ifdef FETCH_HALT_EN
      HALTED: flushS = 1'b1;
`endif
      default: begin
        loadS  = 1'b0;
        flushS = 1'b0;
      end
    endcase
  end

  // PC and fetch state machine with registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stateR   <= IDLE;
      pcR      <= {PC_BITS{1'b0}};
      runningR <= 1'b0;
`ifdef FETCH_HALT_EN
      haltedR  <= 1'b0;
`endif
    end else begin
      case (stateR)
        IDLE: begin
          if (bus.i_start) begin
            stateR   <= RUN;
            runningR <= 1'b1;
          end else begin
            stateR   <= IDLE;
            runningR <= 1'b0;
          end
        end
        RUN: begin
          if (bus.i_branch_taken) begin
            // Low bits are forced to zero; misaligned targets are not trapped.
            pcR <= bus.i_branch_target & ALIGN_MASK;
          end else if (bus.i_stall) begin
            pcR <= pcR;
`ifdef FETCH_HALT_EN
          end else if (haltFetchS) begin
            // HALT word goes into IF/ID this edge; PC stays on it.
            stateR   <= HALTED;
            runningR <= 1'b0;
            haltedR  <= 1'b1;
`endif
          end else begin
            pcR <= pcPlus4S;
          end
        end
`ifdef FETCH_HALT_EN
        HALTED: begin
          stateR   <= HALTED;
          runningR <= 1'b0;
          haltedR  <= 1'b1;
        end
`endif
        default: begin
          stateR   <= IDLE;
          runningR <= 1'b0;
        end
      endcase
    end
  end

  instruction_fetch_if_id_register #(
    .PC_BITS  (PC_BITS),
    .INST_BITS(INST_BITS)
  ) u_ifId (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (loadS),
    .flush     (flushS),
    .instIn    (bus.i_imem_data),
    .pcPlus4In (pcPlus4S),
    .instOut   (instS),
    .pcPlus4Out(pcPlus4OutS),
    .validOut  (validS)
  );

  assign bus.o_instruction = instS;
  assign bus.o_pc_plus4    = pcPlus4OutS;
  assign bus.o_valid       = validS;
  // Opcode is taken straight from the IF/ID word so control sees it in ID.
  assign bus.o_opcode      = instS[INST_BITS-1 -: OPCODE_BITS];
  assign bus.o_running     = runningR;
`ifdef FETCH_HALT_EN
  assign bus.o_halted      = haltedR;
`endif

endmodule
